// File: rtl/md_pkg.sv
// Shared constants for the HI/LO multiply/divide block: opcodes, funct codes, default latencies.
// The SPECIAL2 accumulate encodings are only decoded when MD_MADD_EN is defined.
package md_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [5:0] FN_MADD  = 6'h00;
    localparam logic [5:0] FN_MADDU = 6'h01;
    localparam logic [5:0] FN_MSUB  = 6'h04;
    localparam logic [5:0] FN_MSUBU = 6'h05;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MADD  = 4'd5,
        MD_MADDU = 4'd6,
        MD_MSUB  = 4'd7,
        MD_MSUBU = 4'd8
    } md_op_t;

endpackage

// File: rtl/md_counter.sv
// Loadable latency down-counter: busy while nonzero, commit high during the cycle whose
// closing edge takes the count from 1 to 0.
module md_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             commit
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             busy_r;

    // Next count: load on issue, otherwise decrement toward zero.
    always_comb begin
        cnt_nx_s = cnt_r;
        if (load) begin
            cnt_nx_s = load_val;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_nx_s = cnt_r - CNT_ONE;
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Count and registered busy flag kept in step with each other.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= CNT_ZERO;
            busy_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nx_s;
            busy_r <= (cnt_nx_s != CNT_ZERO);
        end
    end

    assign busy   = busy_r;
    assign commit = (cnt_r == CNT_ONE);

endmodule

// File: rtl/md_ctrl.sv
// E-stage HI/LO multiply/divide controller: decode, arithmetic, HI/LO ownership and stall.
// Define MD_MADD_EN to add the SPECIAL2 madd/maddu/msub/msubu accumulate operations.
module md_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OPCode,
    input  logic [5:0]       FunctCode,
    input  logic             en,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             d_md_use,
    output logic             start,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] md_out,
    output logic             md_rd
);

    localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    md_op_t             op_s;
    logic               is_mfhi_s, is_mflo_s, is_mthi_s, is_mtlo_s;
    logic               busy_s, commit_s, start_s, mt_ok_s;
    logic [CNT_W-1:0]   load_val_s;
    logic [WIDTH-1:0]   hi_r, lo_r, pend_hi_r, pend_lo_r;
    logic [2*WIDTH-1:0] pend_nx_s, acc_s, prod_s_s, prod_u_s;
    logic               div_zero_s;
    logic [WIDTH-1:0]   rt_safe_s, rs_mag_s, rt_mag_s, sq_mag_s, sr_mag_s, sq_s, sr_s, uq_s, ur_s;

    // Instruction decode, gated by en.
    always_comb begin
        op_s      = MD_NONE;
        is_mfhi_s = 1'b0;
        is_mflo_s = 1'b0;
        is_mthi_s = 1'b0;
        is_mtlo_s = 1'b0;
        if (en && (OPCode == OP_SPECIAL)) begin
            case (FunctCode)
                FN_MULT:  op_s = MD_MULT;
                FN_MULTU: op_s = MD_MULTU;
                FN_DIV:   op_s = MD_DIV;
                FN_DIVU:  op_s = MD_DIVU;
                FN_MFHI:  is_mfhi_s = 1'b1;
                FN_MFLO:  is_mflo_s = 1'b1;
                FN_MTHI:  is_mthi_s = 1'b1;
                FN_MTLO:  is_mtlo_s = 1'b1;
                default:  op_s = MD_NONE;
            endcase
`ifdef MD_MADD_EN
        end else if (en && (OPCode == OP_SPECIAL2)) begin
            case (FunctCode)
                FN_MADD:  op_s = MD_MADD;
                FN_MADDU: op_s = MD_MADDU;
                FN_MSUB:  op_s = MD_MSUB;
                FN_MSUBU: op_s = MD_MSUBU;
                default:  op_s = MD_NONE;
            endcase
`endif
        end else begin
            op_s = MD_NONE;
        end
    end

    assign start_s    = (op_s != MD_NONE) && !busy_s;
    assign load_val_s = ((op_s == MD_DIV) || (op_s == MD_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                                 : CNT_W'(MULT_CYCLES);
    // An mt on the commit cycle lands on the same edge and overrides the committed half.
    assign mt_ok_s    = !busy_s || commit_s;

    md_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start_s),
        .load_val (load_val_s),
        .busy     (busy_s),
        .commit   (commit_s)
    );

    // Sign-extended operands give the signed product modulo 2^(2*WIDTH).
    assign prod_s_s = {{WIDTH{rs_val[WIDTH-1]}}, rs_val} * {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
    assign prod_u_s = {W_ZERO, rs_val} * {W_ZERO, rt_val};
    assign acc_s    = {hi_r, lo_r};

    // Signed divide via magnitudes; INT_MIN / -1 naturally wraps to INT_MIN with remainder 0.
    assign div_zero_s = (rt_val == W_ZERO);
    assign rt_safe_s  = div_zero_s ? W_ONE : rt_val;
    assign rs_mag_s   = rs_val[WIDTH-1] ? (-rs_val) : rs_val;
    assign rt_mag_s   = rt_safe_s[WIDTH-1] ? (-rt_safe_s) : rt_safe_s;
    assign sq_mag_s   = rs_mag_s / rt_mag_s;
    assign sr_mag_s   = rs_mag_s % rt_mag_s;
    assign sq_s       = (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]) ? (-sq_mag_s) : sq_mag_s;
    assign sr_s       = rs_val[WIDTH-1] ? (-sr_mag_s) : sr_mag_s;
    assign uq_s       = rs_val / rt_safe_s;
    assign ur_s       = rs_val % rt_safe_s;

    // Full result selected at issue; divide by zero re-latches the current HI/LO.
    always_comb begin
        pend_nx_s = {pend_hi_r, pend_lo_r};
        case (op_s)
            MD_MULT:  pend_nx_s = prod_s_s;
            MD_MULTU: pend_nx_s = prod_u_s;
            MD_DIV:   pend_nx_s = div_zero_s ? acc_s : {sr_s, sq_s};
            MD_DIVU:  pend_nx_s = div_zero_s ? acc_s : {ur_s, uq_s};
`ifdef MD_MADD_EN
            MD_MADD:  pend_nx_s = acc_s + prod_s_s;
            MD_MADDU: pend_nx_s = acc_s + prod_u_s;
            MD_MSUB:  pend_nx_s = acc_s - prod_s_s;
            MD_MSUBU: pend_nx_s = acc_s - prod_u_s;
`endif
            default:  pend_nx_s = {pend_hi_r, pend_lo_r};
        endcase
    end

    // Pending result and architectural HI/LO; mt writes follow the commit so they win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_hi_r <= W_ZERO;
            pend_lo_r <= W_ZERO;
            hi_r      <= W_ZERO;
            lo_r      <= W_ZERO;
        end else begin
            if (start_s) begin
                pend_hi_r <= pend_nx_s[2*WIDTH-1:WIDTH];
                pend_lo_r <= pend_nx_s[WIDTH-1:0];
            end
            if (commit_s) begin
                hi_r <= pend_hi_r;
                lo_r <= pend_lo_r;
            end
            if (is_mthi_s && mt_ok_s) begin
                hi_r <= rs_val;
            end
            if (is_mtlo_s && mt_ok_s) begin
                lo_r <= rs_val;
            end
        end
    end

    // HI/LO read mux for mfhi/mflo.
    always_comb begin
        md_out = W_ZERO;
        if (is_mfhi_s) begin
            md_out = hi_r;
        end else if (is_mflo_s) begin
            md_out = lo_r;
        end else begin
            md_out = W_ZERO;
        end
    end

    assign md_rd    = is_mfhi_s || is_mflo_s;
    assign start    = start_s;
    assign busy     = busy_s;
    assign md_stall = d_md_use && (start_s || busy_s);

endmodule

// File: tb/tb_md_ctrl.sv
// Table-driven bench for md_ctrl with a result scoreboard; MD_MADD_EN adds accumulate checks.
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  OPCode, FunctCode;
    logic        en, d_md_use;
    logic [31:0] rs_val, rt_val;
    logic        start, busy, md_stall, md_rd;
    logic [31:0] md_out;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;
    res_t sb_q[$];

    typedef struct {
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        preset;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;
    localparam int NV = 10;
    vec_t vecs[NV];

    md_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .OPCode    (OPCode),
        .FunctCode (FunctCode),
        .en        (en),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_md_use  (d_md_use),
        .start     (start),
        .busy      (busy),
        .md_stall  (md_stall),
        .md_out    (md_out),
        .md_rd     (md_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic e,
                          input logic [31:0] a, input logic [31:0] b, input logic dmd);
        OPCode    = op;
        FunctCode = fn;
        en        = e;
        rs_val    = a;
        rt_val    = b;
        d_md_use  = dmd;
    endtask

    task automatic preset_hilo(input logic [31:0] h, input logic [31:0] l);
        set_in(OP_SPECIAL, FN_MTHI, 1'b1, h, 32'h0, 1'b0);
        tick();
        set_in(OP_SPECIAL, FN_MTLO, 1'b1, l, 32'h0, 1'b0);
        tick();
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        set_in(OP_SPECIAL, FN_MFHI, 1'b1, 32'h0, 32'h0, 1'b0);
        #1;
        chk({tag, "_md_rd"}, {31'h0, md_rd}, 32'h1);
        chk({tag, "_hi"}, md_out, eh);
        set_in(OP_SPECIAL, FN_MFLO, 1'b1, 32'h0, 32'h0, 1'b0);
        #1;
        chk({tag, "_lo"}, md_out, el);
        set_in(OP_SPECIAL, FN_MFLO, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk({tag, "_out_idle"}, md_out, 32'h0);
        tick();
    endtask

    // Issue one operation, push its expected result, count busy cycles, then pop and compare.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int cyc);
        int   ncyc;
        res_t r;
        set_in(op, fn, 1'b1, a, b, 1'b1);
        #1;
        chk({tag, "_start"}, {31'h0, start}, 32'h1);
        chk({tag, "_stall_issue"}, {31'h0, md_stall}, 32'h1);
        sb_q.push_back('{hi: eh, lo: el});
        tick();
        set_in(OP_SPECIAL, 6'h00, 1'b0, 32'h0, 32'h0, 1'b0);
        ncyc = 0;
        while (busy === 1'b1 && ncyc < 64) begin
            ncyc++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(ncyc), 32'(cyc));
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
        end else begin
            r = sb_q.pop_front();
            read_hilo(tag, r.hi, r.lo);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int nst;
        vecs[0] = '{FN_MULT,  32'hFFFFFFFE, 32'h3, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{FN_MULTU, 32'hFFFFFFFE, 32'h3, 1'b0, 32'h0, 32'h0, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{FN_DIV,   32'hFFFFFFF9, 32'h2, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 32'h0, 32'h80000000, 10};
        vecs[4] = '{FN_DIVU,  32'h00001234, 32'h0, 1'b1, 32'h11, 32'h22, 32'h11, 32'h22, 10};
        vecs[5] = '{FN_DIVU,  32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 32'd2, 32'd14, 10};
        vecs[6] = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[7] = '{FN_DIV,   32'd7, 32'hFFFFFFFE, 1'b0, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFD, 10};
        vecs[8] = '{FN_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h0, 32'h0, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[9] = '{FN_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1, 5};

        reset = 1'b0;
        set_in(OP_SPECIAL, 6'h00, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_start", {31'h0, start}, 32'h0);
        reset = 1'b1;
        tick();
        read_hilo("after_rst", 32'h0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].preset) begin
                preset_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            end
            run_op($sformatf("vec%0d", i), OP_SPECIAL, vecs[i].fn, vecs[i].rs, vecs[i].rt,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cycles);
        end

        // Stall window plus a second mult held in E while busy with different operands.
        set_in(OP_SPECIAL, FN_MULT, 1'b1, 32'd6, 32'd7, 1'b1);
        #1;
        chk("stall_issue", {31'h0, md_stall}, 32'h1);
        nst = md_stall ? 1 : 0;
        tick();
        set_in(OP_SPECIAL, FN_MULT, 1'b1, 32'd5, 32'd5, 1'b1);
        nb = 0;
        while (busy === 1'b1 && nb < 64) begin
            chk("held_no_start", {31'h0, start}, 32'h0);
            if (md_stall) nst++;
            nb++;
            tick();
        end
        chk("held_busy_cycles", 32'(nb), 32'd5);
        chk("stall_cycles", 32'(nst), 32'd6);
        set_in(OP_SPECIAL, 6'h00, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        chk("stall_release", {31'h0, md_stall}, 32'h0);
        read_hilo("held", 32'h0, 32'd42);

        // Reset in the middle of a multiply with three cycles left.
        set_in(OP_SPECIAL, FN_MULT, 1'b1, 32'd9, 32'd9, 1'b0);
        tick();
        set_in(OP_SPECIAL, 6'h00, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        chk("mid_busy", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        set_in(OP_SPECIAL, FN_MFLO, 1'b1, 32'h0, 32'h0, 1'b0);
        #1;
        chk("mid_rst_lo", md_out, 32'h0);
        set_in(OP_SPECIAL, 6'h00, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("post_rst_busy", {31'h0, busy}, 32'h0);
        read_hilo("post_rst", 32'h0, 32'h0);

`ifdef MD_MADD_EN
        preset_hilo(32'h0, 32'd10);
        run_op("madd", OP_SPECIAL2, FN_MADD, 32'd3, 32'd4, 32'h0, 32'd22, 5);
        run_op("msub", OP_SPECIAL2, FN_MSUB, 32'd3, 32'd4, 32'h0, 32'd10, 5);
`else
        set_in(OP_SPECIAL2, FN_MADD, 1'b1, 32'd3, 32'd4, 1'b0);
        #1;
        chk("no_madd_start", {31'h0, start}, 32'h0);
        set_in(OP_SPECIAL, 6'h00, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
